// File: rtl/counter_pkg.sv
// Shared definitions for the up/down counter family: FSM state encoding and default width.
package counter_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/rbs_decrement.sv
// WIDTH-bit ripple-borrow decrementer: a chain of half-subtractors with borrow-in tied to 1.
module rbs_decrement #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  logic [WIDTH:0] borrow;

  assign borrow[0] = 1'b1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_hs
    assign diff[i]       = a[i] ^ borrow[i];
    assign borrow[i + 1] = ~a[i] & borrow[i];
  end

  assign borrow_out = borrow[WIDTH];

endmodule

// File: rtl/down_counter_load.sv
// Loadable down counter / countdown timer with optional auto-reload and a one-cycle expiry pulse.
module down_counter_load
  import counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             zero,
  output logic             busy,
  output logic             expired
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic [WIDTH-1:0] dec_value;
  logic             expired_q, expired_d;
  logic             unused_borrow;
  state_t           state_q, state_d;

  rbs_decrement #(.WIDTH(WIDTH)) u_dec (
    .a          (count_q),
    .diff       (dec_value),
    .borrow_out (unused_borrow)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q   <= '0;
      reload_q  <= '0;
      state_q   <= IDLE;
      expired_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      reload_q  <= reload_d;
      state_q   <= state_d;
      expired_q <= expired_d;
    end
  end

  // Decrement only happens in RUN, where count is never 0, so the chain never wraps.
  always_comb begin
    count_d   = count_q;
    reload_d  = reload_q;
    state_d   = state_q;
    expired_d = 1'b0;
    if (load) begin
      count_d  = load_value;
      reload_d = load_value;
      state_d  = (load_value != '0) ? RUN : IDLE;
    end else if (state_q == RUN && enable) begin
      if (count_q == ONE) begin
        expired_d = 1'b1;
        if (auto_reload) begin
          count_d = reload_q;
        end else begin
          count_d = '0;
          state_d = IDLE;
        end
      end else begin
        count_d = dec_value;
      end
    end
  end

  assign count   = count_q;
  assign zero    = (count_q == '0);
  assign busy    = (state_q == RUN);
  assign expired = expired_q;

endmodule

// File: tb/tb_down_counter_load.sv
// Bench for down_counter_load: directed scenarios plus random traffic against a behavioural timer model.
module tb_down_counter_load;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_value = '0;
  logic         enable = 1'b0;
  logic         auto_reload = 1'b0;
  logic [W-1:0] count;
  logic         zero, busy, expired;

  int checks = 0;
  int failures = 0;

  // Reference model: a timer value, its start value, a running flag and the last pulse.
  int m_count = 0;
  int m_start = 0;
  bit m_running = 0;
  bit m_pulse = 0;

  down_counter_load #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .load_value  (load_value),
    .enable      (enable),
    .auto_reload (auto_reload),
    .count       (count),
    .zero        (zero),
    .busy        (busy),
    .expired     (expired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".count"}, 32'(count), 32'(m_count));
    chk({tag, ".zero"}, 32'(zero), 32'(m_count == 0));
    chk({tag, ".busy"}, 32'(busy), 32'(m_running));
    chk({tag, ".expired"}, 32'(expired), 32'(m_pulse));
  endtask

  // Drive one edge's inputs, advance the model, and compare just after the edge.
  task automatic step(input bit l, input int v, input bit e, input bit a, input string tag);
    load = l;
    load_value = W'(v);
    enable = e;
    auto_reload = a;
    @(posedge clk);
    m_pulse = 0;
    if (l) begin
      m_count = v;
      m_start = v;
      m_running = (v != 0);
    end else if (m_running && e) begin
      if (m_count == 1) begin
        m_pulse = 1;
        if (a) m_count = m_start;
        else begin
          m_count = 0;
          m_running = 0;
        end
      end else begin
        m_count = m_count - 1;
      end
    end
    #1;
    check_model(tag);
  endtask

  task automatic model_reset();
    m_count = 0;
    m_start = 0;
    m_running = 0;
    m_pulse = 0;
  endtask

  initial begin
    int pulses;
    int first_edge;
    int edge_list[$];

    // Reset state
    reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_model("reset");
    chk("reset.zero_const", 32'(zero), 32'd1);
    reset = 1'b1;

    // Reset mid-count at count 5
    step(1, 7, 1, 0, "mc_load");
    step(0, 0, 1, 0, "mc_dec1");
    step(0, 0, 1, 0, "mc_dec2");
    chk("mc.count5", 32'(count), 32'd5);
    #2 reset = 1'b0;
    #1;
    model_reset();
    chk("async_rst.count", 32'(count), 32'd0);
    chk("async_rst.zero", 32'(zero), 32'd1);
    chk("async_rst.busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, "post_rst_hold");

    // Load 3, one-shot
    step(1, 3, 1, 0, "os_load");
    chk("os.count3", 32'(count), 32'd3);
    chk("os.busy", 32'(busy), 32'd1);
    step(0, 0, 1, 0, "os_2");
    step(0, 0, 1, 0, "os_1");
    step(0, 0, 1, 0, "os_0");
    chk("os.expired_at_0", 32'(expired), 32'd1);
    chk("os.busy_drop", 32'(busy), 32'd0);
    step(0, 0, 1, 0, "os_after1");
    step(0, 0, 1, 0, "os_after2");
    chk("os.no_wrap", 32'(count), 32'd0);

    // Load 4, periodic for 12 edges
    step(1, 4, 1, 1, "per_load");
    edge_list.delete();
    for (int k = 1; k <= 12; k++) begin
      step(0, 0, 1, 1, "per_run");
      if (expired) edge_list.push_back(k);
      if (count == 0) chk("per.never_zero", 32'(count), 32'(m_count));
    end
    chk("per.pulse_count", 32'(edge_list.size()), 32'd3);
    if (edge_list.size() == 3) begin
      chk("per.edge_a", 32'(edge_list[0]), 32'd4);
      chk("per.edge_b", 32'(edge_list[1]), 32'd8);
      chk("per.edge_c", 32'(edge_list[2]), 32'd12);
    end

    // Load 6, enable toggling 1,0,1,0...
    step(1, 6, 1, 0, "gap_load");
    first_edge = 0;
    for (int k = 1; k <= 14; k++) begin
      step(0, 0, (k % 2) == 1, 0, "gap_run");
      if (expired && first_edge == 0) first_edge = k;
    end
    chk("gap.expiry_edge", 32'(first_edge), 32'd11);

    // Load colliding with the count==1 expiry edge
    step(1, 2, 1, 0, "col_load");
    step(0, 0, 1, 0, "col_1");
    chk("col.count1", 32'(count), 32'd1);
    step(1, 9, 1, 0, "col_hit");
    chk("col.count9", 32'(count), 32'd9);
    chk("col.no_pulse", 32'(expired), 32'd0);
    chk("col.busy", 32'(busy), 32'd1);

    // Load 0 stays idle
    step(1, 0, 1, 1, "z_load");
    chk("z.busy", 32'(busy), 32'd0);
    chk("z.zero", 32'(zero), 32'd1);
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 1, 1, "z_hold");
      if (expired) pulses++;
    end
    chk("z.no_pulse", 32'(pulses), 32'd0);

    // Load all-ones: 15 enabled edges to expiry
    step(1, 15, 1, 0, "max_load");
    first_edge = 0;
    for (int k = 1; k <= 40 && first_edge == 0; k++) begin
      step(0, 0, 1, 0, "max_run");
      if (expired) first_edge = k;
    end
    chk("max.expiry_edge", 32'(first_edge), 32'd15);

    // Random traffic, with occasional asynchronous reset
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 60) == 0) begin
        @(negedge clk);
        reset = 1'b0;
        #1;
        model_reset();
        check_model("rnd_reset");
        @(negedge clk);
        reset = 1'b1;
      end else begin
        step($urandom_range(0, 9) == 0, $urandom_range(0, (1 << W) - 1),
             $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, "rnd");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
